// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared mode encodings, physical bank indices and FSM states for the register-bank initiator
package regbank_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam logic [4:0] FIQ_BASE = 5'd16;
    localparam logic [4:0] SVC_BASE = 5'd23;
    localparam logic [4:0] ABT_BASE = 5'd25;
    localparam logic [4:0] IRQ_BASE = 5'd27;
    localparam logic [4:0] UND_BASE = 5'd29;
    localparam logic [4:0] PC_IDX   = 5'd15;
    localparam logic [4:0] CPSR_IDX = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_PCW,
        ST_RD,
        ST_RESP
    } state_t;

    // r13 lands on the base slot, r14 on the one after it
    function automatic logic [4:0] banked_idx(input logic [4:0] base, input logic [3:0] r);
        return base + {4'd0, ~r[0]};
    endfunction

endpackage

// File: rtl/regbank_mode_map.sv
// rtl/regbank_mode_map.sv - combinational logical register + CPSR mode to physical bank index
module regbank_mode_map
    import regbank_pkg::*;
(
    input  logic [4:0] mode,
    input  logic [3:0] reg_idx,
    output logic [4:0] phys,
    output logic       bad
);

    logic is_banked13;

    assign is_banked13 = (reg_idx == 4'd13) || (reg_idx == 4'd14);

    always_comb begin
        phys = {1'b0, reg_idx};
        bad  = 1'b0;
        case (mode)
            MODE_USR, MODE_SYS: ;
            MODE_FIQ: if (reg_idx >= 4'd8 && reg_idx <= 4'd14) phys = FIQ_BASE + {1'b0, reg_idx} - 5'd8;
            MODE_SVC: if (is_banked13) phys = banked_idx(SVC_BASE, reg_idx);
            MODE_ABT: if (is_banked13) phys = banked_idx(ABT_BASE, reg_idx);
            MODE_IRQ: if (is_banked13) phys = banked_idx(IRQ_BASE, reg_idx);
            MODE_UND: if (is_banked13) phys = banked_idx(UND_BASE, reg_idx);
            default:  bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/regbank_access_ctrl.sv
// rtl/regbank_access_ctrl.sv - sequences read/write/PC/CPSR requests onto the single register-bank port
// Optional per-cycle trace output when REGBANK_TRACE_EN is defined.
module regbank_access_ctrl
    import regbank_pkg::*;
#(
    parameter logic [31:0] PC_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  mode,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [3:0]  rd_rn,
    input  logic [3:0]  rd_rm,
    output logic        rd_resp_valid,
    input  logic        rd_resp_ready,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_rd,
    input  logic [31:0] wr_data,
    input  logic        pc_wr_valid,
    output logic        pc_wr_ready,
    input  logic [31:0] pc_wr_data,
    input  logic        cpsr_wr_valid,
    output logic        cpsr_wr_ready,
    input  logic [31:0] cpsr_wr_data,
    input  logic [31:0] cpsr_wr_mask,
    output logic [31:0] pc_value,
    output logic        bad_mode,
    output logic [4:0]  bank_address1,
    output logic [4:0]  bank_address2,
    output logic [31:0] bank_write,
    output logic [31:0] bank_pc_write,
    output logic [31:0] bank_cpsr_write,
    output logic [31:0] bank_cpsr_mask,
    output logic        bank_is_active,
    output logic        bank_w,
    output logic        bank_pc_w,
    output logic        bank_cpsr_w,
    input  logic [31:0] bank_read1,
    input  logic [31:0] bank_read2,
    input  logic [31:0] bank_pc_read
);

    state_t      state, next_state;
    logic        sel_wr, sel_pc, sel_rd;
    logic [4:0]  rn_phys, rm_phys, wr_phys;
    logic        rn_bad, rm_bad, wr_bad;
    logic        rn_is_pc, rm_is_pc;
    logic        cpsr_pending;
    logic        cpsr_accept;

    regbank_mode_map u_map_rn (.mode(mode), .reg_idx(rd_rn), .phys(rn_phys), .bad(rn_bad));
    regbank_mode_map u_map_rm (.mode(mode), .reg_idx(rd_rm), .phys(rm_phys), .bad(rm_bad));
    regbank_mode_map u_map_rd (.mode(mode), .reg_idx(wr_rd), .phys(wr_phys), .bad(wr_bad));

    always_comb begin
        next_state = state;
        sel_wr     = 1'b0;
        sel_pc     = 1'b0;
        sel_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                // writes first so a same-cycle read observes the new value
                if (wr_valid) begin
                    sel_wr     = 1'b1;
                    next_state = ST_WR;
                end else if (pc_wr_valid) begin
                    sel_pc     = 1'b1;
                    next_state = ST_PCW;
                end else if (rd_req_valid) begin
                    sel_rd     = 1'b1;
                    next_state = ST_RD;
                end
            end
            ST_WR, ST_PCW: next_state = ST_IDLE;
            ST_RD:         next_state = ST_RESP;
            ST_RESP:       if (rd_resp_ready) next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    assign wr_ready      = sel_wr;
    assign pc_wr_ready   = sel_pc;
    assign rd_req_ready  = sel_rd;
    assign rd_resp_valid = (state == ST_RESP);
    assign cpsr_wr_ready = cpsr_wr_valid && !cpsr_pending;
    assign cpsr_accept   = cpsr_wr_valid && !cpsr_pending;
    assign bank_cpsr_w   = cpsr_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            bank_w          <= 1'b0;
            bank_pc_w       <= 1'b0;
            bank_is_active  <= 1'b0;
            bank_address1   <= '0;
            bank_address2   <= '0;
            bank_write      <= '0;
            bank_pc_write   <= '0;
            bank_cpsr_write <= '0;
            bank_cpsr_mask  <= '0;
            cpsr_pending    <= 1'b0;
            rn_is_pc        <= 1'b0;
            rm_is_pc        <= 1'b0;
            rd_data1        <= '0;
            rd_data2        <= '0;
            pc_value        <= '0;
            bad_mode        <= 1'b0;
        end else begin
            state          <= next_state;
            bank_w         <= sel_wr;
            bank_pc_w      <= sel_pc;
            bank_is_active <= sel_pc || sel_rd;
            bad_mode       <= (sel_wr || sel_pc || sel_rd) && (rn_bad || rm_bad || wr_bad);
            cpsr_pending   <= cpsr_accept;
            if (sel_wr) begin
                bank_address1 <= wr_phys;
                bank_write    <= wr_data;
            end
            if (sel_pc) bank_pc_write <= pc_wr_data;
            if (sel_rd) begin
                bank_address1 <= rn_phys;
                bank_address2 <= rm_phys;
                rn_is_pc      <= ({1'b0, rd_rn} == PC_IDX);
                rm_is_pc      <= ({1'b0, rd_rm} == PC_IDX);
            end
            if (state == ST_RD) begin
                rd_data1 <= rn_is_pc ? bank_pc_read + PC_OFFSET : bank_read1;
                rd_data2 <= rm_is_pc ? bank_pc_read + PC_OFFSET : bank_read2;
                pc_value <= bank_pc_read;
            end
            if (cpsr_accept) begin
                bank_cpsr_write <= cpsr_wr_data;
                bank_cpsr_mask  <= cpsr_wr_mask;
            end
        end
    end

`ifdef REGBANK_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (bank_w)
                $display("regbank: WR   addr=%0d data=%h mode=%b", bank_address1, bank_write, mode);
            if (bank_pc_w)
                $display("regbank: PCW  data=%h mode=%b", bank_pc_write, mode);
            if (bank_is_active && !bank_pc_w)
                $display("regbank: RD   addr=%0d/%0d data=%h/%h mode=%b", bank_address1, bank_address2,
                         bank_read1, bank_read2, mode);
            if (bank_cpsr_w)
                $display("regbank: CPSR addr=%0d data=%h mask=%h mode=%b", CPSR_IDX, bank_cpsr_write,
                         bank_cpsr_mask, mode);
            if (bad_mode)
                $display("regbank: bad_mode pulse mode=%b", mode);
        end
    end
`endif

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// tb/tb_regbank_access_ctrl.sv - directed table-driven bench for regbank_access_ctrl with a behavioural bank
module tb_regbank_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mode;
    logic        rd_req_valid, rd_req_ready;
    logic [3:0]  rd_rn, rd_rm;
    logic        rd_resp_valid, rd_resp_ready;
    logic [31:0] rd_data1, rd_data2;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_rd;
    logic [31:0] wr_data;
    logic        pc_wr_valid, pc_wr_ready;
    logic [31:0] pc_wr_data;
    logic        cpsr_wr_valid, cpsr_wr_ready;
    logic [31:0] cpsr_wr_data, cpsr_wr_mask;
    logic [31:0] pc_value;
    logic        bad_mode;
    logic [4:0]  bank_address1, bank_address2;
    logic [31:0] bank_write, bank_pc_write, bank_cpsr_write, bank_cpsr_mask;
    logic        bank_is_active, bank_w, bank_pc_w, bank_cpsr_w;
    logic [31:0] bank_read1, bank_read2, bank_pc_read;

    int total;
    int bad;

    regbank_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_rn(rd_rn), .rd_rm(rd_rm),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rd(wr_rd), .wr_data(wr_data),
        .pc_wr_valid(pc_wr_valid), .pc_wr_ready(pc_wr_ready), .pc_wr_data(pc_wr_data),
        .cpsr_wr_valid(cpsr_wr_valid), .cpsr_wr_ready(cpsr_wr_ready),
        .cpsr_wr_data(cpsr_wr_data), .cpsr_wr_mask(cpsr_wr_mask),
        .pc_value(pc_value), .bad_mode(bad_mode),
        .bank_address1(bank_address1), .bank_address2(bank_address2),
        .bank_write(bank_write), .bank_pc_write(bank_pc_write),
        .bank_cpsr_write(bank_cpsr_write), .bank_cpsr_mask(bank_cpsr_mask),
        .bank_is_active(bank_is_active), .bank_w(bank_w), .bank_pc_w(bank_pc_w),
        .bank_cpsr_w(bank_cpsr_w),
        .bank_read1(bank_read1), .bank_read2(bank_read2), .bank_pc_read(bank_pc_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural register bank: combinational read, write on the strobe cycle
    logic [31:0] mem [0:31];
    logic [31:0] pc_reg;
    logic        preload;

    assign bank_read1   = mem[bank_address1];
    assign bank_read2   = mem[bank_address2];
    assign bank_pc_read = pc_reg;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
            pc_reg <= 32'h100;
        end else begin
            if (bank_w)    mem[bank_address1] <= bank_write;
            if (bank_pc_w) pc_reg <= bank_pc_write;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [4:0] m, input logic [3:0] rn, input logic [3:0] rm,
                           input logic [4:0] ea1, input logic [4:0] ea2,
                           input logic [31:0] ed1, input logic [31:0] ed2, input logic ebad);
        @(negedge clk);
        mode = m; rd_rn = rn; rd_rm = rm; rd_req_valid = 1'b1; rd_resp_ready = 1'b0;
        #1 chk("rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
        @(negedge clk);
        rd_req_valid = 1'b0;
        chk("rd_addr1", {27'd0, bank_address1}, {27'd0, ea1});
        chk("rd_addr2", {27'd0, bank_address2}, {27'd0, ea2});
        chk("rd_active", {31'd0, bank_is_active}, 32'd1);
        chk("rd_bank_w", {31'd0, bank_w}, 32'd0);
        chk("rd_bad_mode", {31'd0, bad_mode}, {31'd0, ebad});
        @(negedge clk);
        chk("resp_valid", {31'd0, rd_resp_valid}, 32'd1);
        chk("rd_data1", rd_data1, ed1);
        chk("rd_data2", rd_data2, ed2);
        rd_resp_ready = 1'b1;
        @(negedge clk);
        rd_resp_ready = 1'b0;
        chk("resp_done", {31'd0, rd_resp_valid}, 32'd0);
    endtask

    function automatic logic [31:0] strobes();
        return {28'd0, bank_w, bank_is_active, bank_pc_w, bank_cpsr_w};
    endfunction

    typedef struct {
        logic [4:0]  mode;
        logic [3:0]  rn, rm;
        logic [4:0]  a1, a2;
        logic [31:0] d1, d2;
        logic        bad;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{5'b10000, 4'd1,  4'd14, 5'd1,  5'd14, 32'h1001, 32'h100E, 1'b0};
        vecs[1] = '{5'b10001, 4'd8,  4'd14, 5'd16, 5'd22, 32'h1010, 32'h1016, 1'b0};
        vecs[2] = '{5'b10011, 4'd13, 4'd15, 5'd23, 5'd15, 32'h1017, 32'h108,  1'b0};
        vecs[3] = '{5'b10111, 4'd14, 4'd13, 5'd26, 5'd25, 32'h101A, 32'h1019, 1'b0};
        vecs[4] = '{5'b10010, 4'd13, 4'd7,  5'd27, 5'd7,  32'h101B, 32'h1007, 1'b0};
        vecs[5] = '{5'b11011, 4'd14, 4'd12, 5'd30, 5'd12, 32'h101E, 32'h100C, 1'b0};
        vecs[6] = '{5'b11111, 4'd13, 4'd15, 5'd13, 5'd15, 32'h100D, 32'h108,  1'b0};
        vecs[7] = '{5'b00000, 4'd14, 4'd9,  5'd14, 5'd9,  32'h100E, 32'h1009, 1'b1};

        total = 0; bad = 0;
        rst_n = 1'b0; preload = 1'b1; mode = 5'b10000;
        rd_req_valid = 0; rd_rn = 0; rd_rm = 0; rd_resp_ready = 0;
        wr_valid = 0; wr_rd = 0; wr_data = 0; pc_wr_valid = 0; pc_wr_data = 0;
        cpsr_wr_valid = 0; cpsr_wr_data = 0; cpsr_wr_mask = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readies", {28'd0, rd_req_ready, wr_ready, pc_wr_ready, cpsr_wr_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
        chk("rst_data", rd_data1 | rd_data2 | pc_value, 32'd0);
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_buses", {22'd0, bank_address1, bank_address2} | bank_write | bank_pc_write
                         | bank_cpsr_write | bank_cpsr_mask, 32'd0);
        chk("rst_bad_mode", {31'd0, bad_mode}, 32'd0);
        preload = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            do_read(vecs[i].mode, vecs[i].rn, vecs[i].rm, vecs[i].a1, vecs[i].a2,
                    vecs[i].d1, vecs[i].d2, vecs[i].bad);

        // FIQ write of r9, then read it back through the banked slot
        @(negedge clk);
        mode = 5'b10001; wr_valid = 1'b1; wr_rd = 4'd9; wr_data = 32'hDEADBEEF;
        #1 chk("fiq_wr_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("fiq_bank_w", {31'd0, bank_w}, 32'd1);
        chk("fiq_wr_active", {31'd0, bank_is_active}, 32'd0);
        chk("fiq_wr_addr", {27'd0, bank_address1}, 32'd17);
        chk("fiq_wr_data", bank_write, 32'hDEADBEEF);
        do_read(5'b10001, 4'd9, 4'd1, 5'd17, 5'd1, 32'hDEADBEEF, 32'h1001, 1'b0);

        // same-cycle write and read of r3: write wins, read sees the new value
        @(negedge clk);
        mode = 5'b10000; wr_valid = 1'b1; wr_rd = 4'd3; wr_data = 32'h55;
        rd_req_valid = 1'b1; rd_rn = 4'd3; rd_rm = 4'd0;
        #1 chk("same_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("same_rd_blocked", {31'd0, rd_req_ready}, 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("same_bank_w", {31'd0, bank_w}, 32'd1);
        chk("same_wr_addr", {27'd0, bank_address1}, 32'd3);
        chk("same_rd_wait", {31'd0, rd_req_ready}, 32'd0);
        do_read(5'b10000, 4'd3, 4'd0, 5'd3, 5'd0, 32'h55, 32'h1000, 1'b0);

        // CPSR write landing while a read is in RD
        @(negedge clk);
        mode = 5'b10000; rd_req_valid = 1'b1; rd_rn = 4'd2; rd_rm = 4'd4; rd_resp_ready = 1'b0;
        @(negedge clk);
        rd_req_valid = 1'b0;
        cpsr_wr_valid = 1'b1; cpsr_wr_data = 32'h000000D3; cpsr_wr_mask = 32'h000000FF;
        #1 chk("cpsr_ready", {31'd0, cpsr_wr_ready}, 32'd1);
        chk("cpsr_not_yet", {31'd0, bank_cpsr_w}, 32'd0);
        @(negedge clk);
        chk("cpsr_pulse", {31'd0, bank_cpsr_w}, 32'd1);
        chk("cpsr_data", bank_cpsr_write, 32'h000000D3);
        chk("cpsr_mask", bank_cpsr_mask, 32'h000000FF);
        chk("cpsr_ready_low", {31'd0, cpsr_wr_ready}, 32'd0);
        chk("cpsr_rd_data1", rd_data1, 32'h1002);
        chk("cpsr_rd_data2", rd_data2, 32'h1004);
        cpsr_wr_valid = 1'b0;
        @(negedge clk);
        chk("cpsr_single", {31'd0, bank_cpsr_w}, 32'd0);
        rd_resp_ready = 1'b1;
        @(negedge clk);
        rd_resp_ready = 1'b0;

        // PC write then read r15 as an operand
        @(negedge clk);
        pc_wr_valid = 1'b1; pc_wr_data = 32'h200;
        #1 chk("pc_wr_ready", {31'd0, pc_wr_ready}, 32'd1);
        @(negedge clk);
        pc_wr_valid = 1'b0;
        chk("pcw_strobes", strobes(), 32'b0110);
        chk("pcw_data", bank_pc_write, 32'h200);
        do_read(5'b10000, 4'd15, 4'd4, 5'd15, 5'd4, 32'h208, 32'h1004, 1'b0);
        chk("pc_value", pc_value, 32'h200);

        // unmapped mode read, then a long response stall
        @(negedge clk);
        mode = 5'b10101; rd_req_valid = 1'b1; rd_rn = 4'd13; rd_rm = 4'd0;
        #1 chk("bad_pre", {31'd0, bad_mode}, 32'd0);
        @(negedge clk);
        rd_req_valid = 1'b0;
        chk("bad_pulse", {31'd0, bad_mode}, 32'd1);
        chk("bad_addr", {27'd0, bank_address1}, 32'd13);
        @(negedge clk);
        chk("bad_once", {31'd0, bad_mode}, 32'd0);
        wr_valid = 1'b1; wr_rd = 4'd5; wr_data = 32'h77;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_wr_ready", {31'd0, wr_ready}, 32'd0);
            @(negedge clk);
            chk("stall_valid", {31'd0, rd_resp_valid}, 32'd1);
            chk("stall_data1", rd_data1, 32'h100D);
            chk("stall_strobes", strobes(), 32'd0);
        end
        wr_valid = 1'b0; rd_resp_ready = 1'b1;
        @(negedge clk);
        rd_resp_ready = 1'b0;
        chk("stall_done", {31'd0, rd_resp_valid}, 32'd0);

        // reset while a response is pending
        @(negedge clk);
        mode = 5'b10000; rd_req_valid = 1'b1; rd_rn = 4'd1; rd_rm = 4'd2;
        @(negedge clk);
        rd_req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, rd_resp_valid}, 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_valid", {31'd0, rd_resp_valid}, 32'd0);
        chk("mid_rst_data", rd_data1 | rd_data2 | pc_value, 32'd0);
        chk("mid_rst_strobes", strobes(), 32'd0);
        chk("mid_rst_addr", {27'd0, bank_address1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", strobes() | {31'd0, rd_resp_valid}, 32'd0);
        end
        do_read(5'b10000, 4'd1, 4'd2, 5'd1, 5'd2, 32'h1001, 32'h1002, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
